// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, waits for a stable lock, then releases
// the downstream reset. Retries on lock timeout and relocks on lock loss or request.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYC    = 10,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned MAX_RETRIES      = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRun,
        StFault
    } state_e;

    localparam logic [31:0] RstLast     = 32'(RST_PULSE_CYC - 1);
    localparam logic [31:0] TimeoutLast = 32'(LOCK_TIMEOUT_CYC - 1);
    // The WAIT_LOCK cycle that saw lock_s=1 counts as the first stable cycle.
    localparam logic [31:0] StableLast  =
        (LOCK_STABLE_CYC >= 2) ? 32'(LOCK_STABLE_CYC - 2) : 32'd0;
    localparam logic [3:0]  MaxRetries  = 4'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  retry_d;
    logic [7:0]  loss_d;
    logic        sync_q, lock_s;
    logic        pll_rst_d, sys_rst_n_d, ready_d, fault_d;

    always_comb begin
        state_d = state_q;
        retry_d = retry_cnt;
        loss_d  = loss_cnt;
        unique case (state_q)
            StResetPll: begin
                if (timer_q >= RstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (lock_s) begin
                    state_d = StStable;
                end else if (timer_q >= TimeoutLast) begin
                    retry_d = retry_cnt + 4'd1;
                    state_d = (retry_d == MaxRetries) ? StFault : StResetPll;
                end
            end
            StStable: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                end else if (timer_q >= StableLast) begin
                    state_d = StRun;
                    retry_d = 4'd0;
                end
            end
            StRun: begin
                if (!lock_s) begin
                    state_d = StResetPll;
                    if (loss_cnt != 8'hff) loss_d = loss_cnt + 8'd1;
                end else if (relock_req) begin
                    state_d = StResetPll;
                end
            end
            StFault: begin
                if (relock_req) begin
                    state_d = StResetPll;
                    retry_d = 4'd0;
                end
            end
            default: state_d = StResetPll;
        endcase

        if (state_d != state_q) begin
            timer_d = 32'd0;
        end else if (timer_q != 32'hffff_ffff) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = timer_q;
        end

        // Decode from the next state so outputs change on the same edge as the state.
        pll_rst_d   = (state_d == StResetPll) || (state_d == StFault);
        sys_rst_n_d = (state_d == StRun);
        ready_d     = (state_d == StRun);
        fault_d     = (state_d == StFault);
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q   <= StResetPll;
            timer_q   <= 32'd0;
            sync_q    <= 1'b0;
            lock_s    <= 1'b0;
            retry_cnt <= 4'd0;
            loss_cnt  <= 8'd0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sync_q    <= pll_locked;
            lock_s    <= sync_q;
            retry_cnt <= retry_d;
            loss_cnt  <= loss_d;
            pll_rst   <= pll_rst_d;
            sys_rst_n <= sys_rst_n_d;
            ready     <= ready_d;
            fault     <= fault_d;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with shortened timing parameters.
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYC   (4),
        .LOCK_STABLE_CYC (8),
        .LOCK_TIMEOUT_CYC(20),
        .MAX_RETRIES     (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .fault     (fault),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Advance n edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            tick(1);
            n++;
        end
        check(tag, 32'(ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick(3);
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_retry", 32'(retry_cnt), 32'd0);
        check("rst_loss", 32'(loss_cnt), 32'd0);

        // Nominal bring-up
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check("pulse_pll_rst", 32'(pll_rst), (i < 4) ? 32'd1 : 32'd0);
        end
        check("wait_sys_rst_n", 32'(sys_rst_n), 32'd0);
        tick(5);
        pll_locked = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check("lock_lat_ready", 32'(ready), (k == 10) ? 32'd1 : 32'd0);
            check("lock_lat_sys_rst_n", 32'(sys_rst_n), (k == 10) ? 32'd1 : 32'd0);
        end
        check("run_retry", 32'(retry_cnt), 32'd0);
        check("run_pll_rst", 32'(pll_rst), 32'd0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        tick(2);
        check("loss_still_ready", 32'(ready), 32'd1);
        tick(1);
        check("loss_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("loss_pll_rst", 32'(pll_rst), 32'd1);
        check("loss_cnt_1", 32'(loss_cnt), 32'd1);

        // No lock: two timeout windows then FAULT
        tick(4);
        check("win1_pll_rst", 32'(pll_rst), 32'd0);
        tick(5);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("relock_ignored_wait", 32'(pll_rst), 32'd0);
        tick(13);
        check("win1_end_retry", 32'(retry_cnt), 32'd0);
        check("win1_end_pll_rst", 32'(pll_rst), 32'd0);
        tick(1);
        check("timeout1_retry", 32'(retry_cnt), 32'd1);
        check("timeout1_pll_rst", 32'(pll_rst), 32'd1);
        tick(4);
        check("win2_pll_rst", 32'(pll_rst), 32'd0);
        tick(19);
        check("win2_end_fault", 32'(fault), 32'd0);
        tick(1);
        check("fault_set", 32'(fault), 32'd1);
        check("fault_retry", 32'(retry_cnt), 32'd2);
        check("fault_pll_rst", 32'(pll_rst), 32'd1);
        tick(10);
        check("fault_held", 32'(fault), 32'd1);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("fault_exit", 32'(fault), 32'd0);
        check("fault_exit_retry", 32'(retry_cnt), 32'd0);
        check("fault_exit_pll_rst", 32'(pll_rst), 32'd1);

        // Glitchy lock during STABLE
        tick(4);
        pll_locked = 1'b1;
        tick(3);
        check("stable_ready", 32'(ready), 32'd0);
        check("stable_pll_rst", 32'(pll_rst), 32'd0);
        tick(4);
        pll_locked = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            check("glitch_ready", 32'(ready), 32'd0);
        end
        pll_locked = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check("relock_lat_ready", 32'(ready), (k == 10) ? 32'd1 : 32'd0);
        end

        // Relock request alone
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("req_pll_rst", 32'(pll_rst), 32'd1);
        check("req_ready", 32'(ready), 32'd0);
        check("req_loss", 32'(loss_cnt), 32'd1);
        wait_ready("req_rerun");

        // Loss and relock in the same cycle
        pll_locked = 1'b0;
        tick(2);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        check("both_pll_rst", 32'(pll_rst), 32'd1);
        check("both_loss", 32'(loss_cnt), 32'd2);

        // Saturation of loss_cnt
        for (int i = 0; i < 256; i++) begin
            pll_locked = 1'b1;
            wait_ready("sat_bringup");
            pll_locked = 1'b0;
            tick(3);
        end
        check("loss_sat", 32'(loss_cnt), 32'd255);

        // Reset asserted in STABLE
        pll_locked = 1'b1;
        tick(7);
        check("pre_rst_pll_rst", 32'(pll_rst), 32'd0);
        check("pre_rst_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        tick(1);
        check("mid_rst_pll_rst", 32'(pll_rst), 32'd1);
        check("mid_rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_fault", 32'(fault), 32'd0);
        check("mid_rst_retry", 32'(retry_cnt), 32'd0);
        check("mid_rst_loss", 32'(loss_cnt), 32'd0);
        rst = 1'b1;
        tick(3);
        check("restart_pll_rst_hi", 32'(pll_rst), 32'd1);
        tick(1);
        check("restart_pll_rst_lo", 32'(pll_rst), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_PULSE_CYC, default 10, number of refclk cycles pll_rst is held high per PLL reset attempt (legal range >=1).
REQ-002 Parameter LOCK_STABLE_CYC, default 1024, number of consecutive synchronized-lock cycles required before release (legal range >=1).
REQ-003 Parameter LOCK_TIMEOUT_CYC, default 50000, number of refclk cycles allowed for lock per attempt (legal range >=1; 1 ms at 50 MHz).
REQ-004 Parameter MAX_RETRIES, default 3, number of failed lock attempts before FAULT (legal range 1-15).
REQ-005 refclk  input  1  free-running 50 MHz reference clock; the only clock in the block.
REQ-006 rst  input  1  synchronous, active-low reset; sampled on the rising edge of refclk.
REQ-007 pll_locked  input  1  PLL locked indication; asynchronous to refclk.
REQ-008 relock_req  input  1  single-cycle request to re-run the PLL bring-up sequence.
REQ-009 pll_rst  output  1  active-high reset driven to the PLL.
REQ-010 sys_rst_n  output  1  active-low reset for logic clocked by the PLL outputs.
REQ-011 ready  output  1  high only while in RUN.
REQ-012 fault  output  1  high only while in FAULT.
REQ-013 retry_cnt  output  4  failed lock attempts within the current bring-up.
REQ-014 loss_cnt  output  8  lock-loss events seen in RUN; saturates at 255.

Function
REQ-015 The block SHALL synchronize pll_locked through a 2-flop synchronizer to form lock_s; all decisions SHALL use lock_s only.
REQ-016 The FSM SHALL have the states RESET_PLL, WAIT_LOCK, STABLE, RUN and FAULT, with one 32-bit cycle timer that is cleared on every state change.
REQ-017 All outputs SHALL be registered and SHALL reflect the new state on the same edge as the state change.
REQ-018 Output decode SHALL be: pll_rst=1 in RESET_PLL and FAULT; sys_rst_n=1 only in RUN; ready=1 only in RUN; fault=1 only in FAULT.
REQ-019 RESET_PLL SHALL last exactly RST_PULSE_CYC cycles and SHALL then go to WAIT_LOCK.
REQ-020 In WAIT_LOCK, lock_s=1 SHALL cause a transition to STABLE.
REQ-021 In WAIT_LOCK, if LOCK_TIMEOUT_CYC cycles elapse without lock_s=1, the block SHALL increment retry_cnt and then:
 - go to FAULT if the incremented value equals MAX_RETRIES;
 - otherwise go to RESET_PLL.
REQ-022 In STABLE, lock_s=0 SHALL cause a return to WAIT_LOCK with the timer cleared and retry_cnt unchanged.
REQ-023 In STABLE, after lock_s has been 1 for LOCK_STABLE_CYC consecutive cycles (counting the entry cycle), the block SHALL go to RUN and clear retry_cnt.
REQ-024 In RUN, lock_s=0 SHALL cause a transition to RESET_PLL and increment loss_cnt, saturating at 255.
REQ-025 In RUN, relock_req=1 SHALL cause a transition to RESET_PLL without incrementing loss_cnt.
REQ-026 If lock loss and relock_req occur in the same RUN cycle, the block SHALL go to RESET_PLL and loss_cnt SHALL increment.
REQ-027 In FAULT, relock_req=1 SHALL clear retry_cnt and go to RESET_PLL; otherwise the block SHALL remain in FAULT indefinitely.
REQ-028 relock_req SHALL be ignored in RESET_PLL, WAIT_LOCK and STABLE.
REQ-029 sys_rst_n SHALL never be 1 while pll_rst is 1.

Reset
REQ-030 While rst=0 at a refclk edge, the block SHALL enter RESET_PLL with timer=0, retry_cnt=0, loss_cnt=0, synchronizer flops=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0.
REQ-031 Asserting rst in any state, including mid-sequence, SHALL restart the sequence from REQ-030 on the next edge.

Verification
REQ-032 Bench parameters SHALL be RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=20, MAX_RETRIES=2.
REQ-033 Nominal bring-up: release rst; raise pll_locked 5 cycles after pll_rst falls -> pll_rst high for exactly 4 cycles; ready=1 and sys_rst_n=1 exactly 2+8 cycles after pll_locked rises; retry_cnt=0.
REQ-034 No lock: hold pll_locked=0 -> two 20-cycle WAIT_LOCK windows; retry_cnt reads 1 then 2; then fault=1 and pll_rst=1 held. Pulsing relock_req -> retry_cnt=0 and RESET_PLL re-entered.
REQ-035 Glitchy lock: drop pll_locked for 3 cycles at STABLE cycle 5 -> return to WAIT_LOCK and ready stays 0; once stable, RUN is reached after a fresh 8-cycle count.
REQ-036 Loss in RUN: drop pll_locked -> sys_rst_n=0 and pll_rst=1 within 3 cycles; loss_cnt=1. Repeat 256 losses -> loss_cnt=255.
REQ-037 Simultaneous and reset: relock_req together with lock loss in RUN -> loss_cnt increments; rst=0 asserted in STABLE -> all outputs at reset values on the next edge.
